hazard_unit: RTL
================

# hazard_unit

Pipeline hazard detector that produces the `hazard` input consumed by the instruction decoder/control unit. It tracks in-flight register destinations in EX and MEM with a registered scoreboard and holds the pipeline behind multi-cycle DIV operations. Each cycle it compares the ID-stage instruction's sources against the scoreboard, then asserts `hazard` together with the PC and IF/ID stall enables. The decoder turns that `hazard` into a bubble. No forwarding exists, so every RAW dependency on EX or MEM stalls.

## Interface
- DIV_LATENCY, 4: total cycles a DIV occupies EX; must be at least 1.
- STALL_CNT_W, 16: width of the saturating stall-cycle performance counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  6  ID opcode, using the decoder's encoding.
- id_rs  in  5  first source register.
- id_rt  in  5  second source register.
- id_dest  in  5  destination register.
- branch_taken  in  1  EX resolved a taken J, JR or BEQ this cycle.
- hazard  out  1  insert bubble; drives the decoder's hazard input.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold the IF/ID register.
- flush  out  1  squash the IF/ID contents.
- div_busy  out  1  a DIV is still occupying EX.
- stall_cycles  out  STALL_CNT_W  count of cycles with `hazard`=1; saturates at all-ones.

## Operation
- **Source use by opcode:**
  - rs and rt: 0x01 ADDU, 0x06 DIV, 0x09 BEQ, 0x0B SC.
  - rs only: 0x02 ADDI, 0x03 SUBIU, 0x04 SLTI, 0x08 JR, 0x0A LL.
  - no sources: 0x05 LUI, 0x07 J, and any undefined opcode.
- **Destination write by opcode:** 0x01–0x06 and 0x0A write `id_dest`; all other opcodes write nothing.
- **Register 0** never matches; it causes no hazard and is never tracked.
- **Scoreboard:** two slots, {ex_wr, ex_dest} and {mem_wr, mem_dest}. WB is not tracked, because the register file writes before it reads within a cycle.
- **RAW condition** `raw`: id_valid, and a used source is non-zero, and that source equals a valid dest in either the EX or the MEM slot.
- **Hazard equation:** `hazard = pc_stall = ifid_stall = !rst & !branch_taken & id_valid & (raw | div_busy)`.
- **Flush:** `flush = !rst & branch_taken`. Flush takes precedence over any stall.
- **Scoreboard advance, normal case** (`div_busy`=0):
  - MEM slot takes the EX slot.
  - EX slot takes the ID instruction if it issues, i.e. id_valid, no hazard and no flush.
  - Otherwise EX slot takes a bubble (wr=0).
- **Scoreboard advance, DIV in EX** (`div_busy`=1):
  - EX slot holds its contents.
  - MEM slot takes a bubble.
- **DIV counter:**
  - When a DIV issues into EX, `div_cnt` loads DIV_LATENCY-1.
  - `div_busy = (div_cnt != 0)`.
  - `div_cnt` decrements each cycle while non-zero.
  - With DIV_LATENCY=1, DIV never stalls.
- **Taken branch during a DIV:** `branch_taken` does not clear `div_cnt`.
- **Performance counter:** `stall_cycles` increments on every cycle with `hazard`=1 and saturates at all-ones.

## Timing
- **Reset:** on the rst edge, both scoreboard slots are cleared, `div_cnt`=0 and `stall_cycles`=0.
  - While rst=1, `hazard`, `pc_stall`, `ifid_stall`, `flush` and `div_busy` are all 0.
  - Reset in the middle of a DIV aborts it: `div_busy`=0 in the first cycle after rst falls.
- **Output timing:** `hazard` and `flush` are combinational from the current ID inputs plus registered state; they take effect in the same cycle.
- **Dependency distance 1** (producer in the previous ID cycle): `hazard` high for 2 cycles, while the producer is in EX and then MEM.
- **Dependency distance 2:** `hazard` high for 1 cycle. **Distance 3 or more:** no hazard.
- **DIV stall length:** DIV issued at cycle t. `div_busy` is 1 for cycles t+1 through t+DIV_LATENCY-1. The next instruction issues at t+DIV_LATENCY at the earliest, and a consumer of the DIV result stalls 2 more cycles beyond that.
- **Branch during a stall:** if `branch_taken` arrives while `hazard`=1, then `hazard`=0 and `flush`=1 in that cycle, and the stalled instruction is discarded without entering the scoreboard.
- **Back-to-back DIVs:** the second DIV stalls until `div_busy` clears, then reloads `div_cnt`.

## Test plan
- ADDU r3←r1,r2, then ADDI r4←r3 in the next ID cycle -> `hazard` =1 for exactly 2 cycles; `stall_cycles`=2.
- ADDU r3, then an independent instruction, then SLTI reading r3 -> `hazard` =1 for exactly 1 cycle. Repeat with the dependency on r0 -> no hazard.
- DIV r5 with DIV_LATENCY=4, followed by ADDU r6←r5,r1 -> `div_busy` =1 for 3 cycles, then RAW `hazard` for 2 more cycles; `stall_cycles`=5.
- LUI, J or an undefined opcode (0x3F) whose rs/rt fields match an in-flight dest -> `hazard` stays 0.
- BEQ RAW stall with `branch_taken`=1 in the 2nd stall cycle -> that cycle `hazard`=0, `flush`=1; the following cycle the EX slot holds a bubble.
- Assert rst during the 2nd cycle of a DIV -> all outputs 0 in the cycle after reset; a dependent instruction issues without stall.

Source files
------------

// File: rtl/hazard_unit_if.sv
// ID-stage request and stall/flush response bundle between the decoder and hazard_unit.
interface hazard_unit_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [5:0]             id_opcode;
    logic [4:0]             id_rs;
    logic [4:0]             id_rt;
    logic [4:0]             id_dest;
    logic                   branch_taken;
    logic                   hazard;
    logic                   pc_stall;
    logic                   ifid_stall;
    logic                   flush;
    logic                   div_busy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_dest, branch_taken,
        input  hazard, pc_stall, ifid_stall, flush, div_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_dest, branch_taken,
        output hazard, pc_stall, ifid_stall, flush, div_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// RAW hazard detector with an EX/MEM destination scoreboard and a multi-cycle DIV hold.
module hazard_unit #(
    parameter int DIV_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hu
);
    localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    localparam logic [5:0] OP_ADDU  = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_SUBIU = 6'h03;
    localparam logic [5:0] OP_SLTI  = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h05;
    localparam logic [5:0] OP_DIV   = 6'h06;
    localparam logic [5:0] OP_JR    = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h09;
    localparam logic [5:0] OP_LL    = 6'h0A;
    localparam logic [5:0] OP_SC    = 6'h0B;

    logic                   ex_wr_q, ex_wr_d;
    logic [4:0]             ex_dest_q, ex_dest_d;
    logic                   mem_wr_q, mem_wr_d;
    logic [4:0]             mem_dest_q, mem_dest_d;
    logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic uses_rs, uses_rt, writes_dest;
    logic rs_hit, rt_hit, raw, busy, hazard, flush, issue;

    always_comb begin
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        writes_dest = 1'b0;
        unique case (hu.id_opcode)
            OP_ADDU, OP_DIV, OP_BEQ, OP_SC: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_ADDI, OP_SUBIU, OP_SLTI, OP_JR, OP_LL: uses_rs = 1'b1;
            default: ;
        endcase
        unique case (hu.id_opcode)
            OP_ADDU, OP_ADDI, OP_SUBIU, OP_SLTI, OP_LUI, OP_DIV, OP_LL: writes_dest = 1'b1;
            default: ;
        endcase
    end

    // Register 0 is never a real dependency, so a zero source can never hit.
    assign rs_hit = uses_rs && (hu.id_rs != 5'd0) &&
                    ((ex_wr_q && (ex_dest_q == hu.id_rs)) || (mem_wr_q && (mem_dest_q == hu.id_rs)));
    assign rt_hit = uses_rt && (hu.id_rt != 5'd0) &&
                    ((ex_wr_q && (ex_dest_q == hu.id_rt)) || (mem_wr_q && (mem_dest_q == hu.id_rt)));
    assign raw    = hu.id_valid && (rs_hit || rt_hit);
    assign busy   = (div_cnt_q != '0);
    assign hazard = !rst && !hu.branch_taken && hu.id_valid && (raw || busy);
    assign flush  = !rst && hu.branch_taken;
    assign issue  = hu.id_valid && !hazard && !flush;

    always_comb begin
        ex_wr_d    = ex_wr_q;
        ex_dest_d  = ex_dest_q;
        mem_wr_d   = mem_wr_q;
        mem_dest_d = mem_dest_q;
        div_cnt_d  = div_cnt_q;
        stall_d    = stall_q;

        // While a DIV occupies EX it stays put and MEM drains to a bubble.
        if (busy) begin
            mem_wr_d   = 1'b0;
            mem_dest_d = '0;
        end else begin
            mem_wr_d   = ex_wr_q;
            mem_dest_d = ex_dest_q;
            ex_wr_d    = issue && writes_dest && (hu.id_dest != 5'd0);
            ex_dest_d  = ex_wr_d ? hu.id_dest : '0;
        end

        if (issue && (hu.id_opcode == OP_DIV)) begin
            div_cnt_d = CNT_W'(DIV_LATENCY - 1);
        end else if (busy) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end

        if (hazard && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wr_q    <= 1'b0;
            ex_dest_q  <= '0;
            mem_wr_q   <= 1'b0;
            mem_dest_q <= '0;
            div_cnt_q  <= '0;
            stall_q    <= '0;
        end else begin
            ex_wr_q    <= ex_wr_d;
            ex_dest_q  <= ex_dest_d;
            mem_wr_q   <= mem_wr_d;
            mem_dest_q <= mem_dest_d;
            div_cnt_q  <= div_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign hu.hazard       = hazard;
    assign hu.pc_stall     = hazard;
    assign hu.ifid_stall   = hazard;
    assign hu.flush        = flush;
    assign hu.div_busy     = !rst && busy;
    assign hu.stall_cycles = stall_q;
endmodule
